// File: rtl/morse_pkg.sv
// Shared Morse encoder types: FSM states, code records, unit constants and the
// ASCII-to-Morse lookup.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMark,
    StSymGap,
    StCharGap,
    StWordGap
  } state_e;

  // Pattern is MSB-first and left-aligned: pattern[4] is the first symbol, 1 = dash.
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pattern;
  } morse_code_t;

  localparam logic [2:0] DotUnits     = 3'd1;
  localparam logic [2:0] DashUnits    = 3'd3;
  localparam logic [2:0] SymGapUnits  = 3'd1;
  localparam logic [2:0] CharGapUnits = 3'd3;
  localparam logic [2:0] WordGapUnits = 3'd4;

  function automatic morse_code_t mk_code(input logic [2:0] len, input logic [4:0] pattern);
    morse_code_t code;
    code.valid   = 1'b1;
    code.len     = len;
    code.pattern = pattern;
    return code;
  endfunction

  // A valid code of length 0 marks the space character (word gap).
  function automatic morse_code_t morse_lookup(input logic [7:0] c);
    morse_code_t code;
    logic [7:0]  u;
    u    = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    code = '0;
    case (u)
      8'h20: code = mk_code(3'd0, 5'b00000);
      8'h30: code = mk_code(3'd5, 5'b11111);
      8'h31: code = mk_code(3'd5, 5'b01111);
      8'h32: code = mk_code(3'd5, 5'b00111);
      8'h33: code = mk_code(3'd5, 5'b00011);
      8'h34: code = mk_code(3'd5, 5'b00001);
      8'h35: code = mk_code(3'd5, 5'b00000);
      8'h36: code = mk_code(3'd5, 5'b10000);
      8'h37: code = mk_code(3'd5, 5'b11000);
      8'h38: code = mk_code(3'd5, 5'b11100);
      8'h39: code = mk_code(3'd5, 5'b11110);
      8'h41: code = mk_code(3'd2, 5'b01000);
      8'h42: code = mk_code(3'd4, 5'b10000);
      8'h43: code = mk_code(3'd4, 5'b10100);
      8'h44: code = mk_code(3'd3, 5'b10000);
      8'h45: code = mk_code(3'd1, 5'b00000);
      8'h46: code = mk_code(3'd4, 5'b00100);
      8'h47: code = mk_code(3'd3, 5'b11000);
      8'h48: code = mk_code(3'd4, 5'b00000);
      8'h49: code = mk_code(3'd2, 5'b00000);
      8'h4a: code = mk_code(3'd4, 5'b01110);
      8'h4b: code = mk_code(3'd3, 5'b10100);
      8'h4c: code = mk_code(3'd4, 5'b01000);
      8'h4d: code = mk_code(3'd2, 5'b11000);
      8'h4e: code = mk_code(3'd2, 5'b10000);
      8'h4f: code = mk_code(3'd3, 5'b11100);
      8'h50: code = mk_code(3'd4, 5'b01100);
      8'h51: code = mk_code(3'd4, 5'b11010);
      8'h52: code = mk_code(3'd3, 5'b01000);
      8'h53: code = mk_code(3'd3, 5'b00000);
      8'h54: code = mk_code(3'd1, 5'b10000);
      8'h55: code = mk_code(3'd3, 5'b00100);
      8'h56: code = mk_code(3'd4, 5'b00010);
      8'h57: code = mk_code(3'd3, 5'b01100);
      8'h58: code = mk_code(3'd4, 5'b10010);
      8'h59: code = mk_code(3'd4, 5'b10110);
      8'h5a: code = mk_code(3'd4, 5'b11000);
      default: code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Counts P-cycle units while running and flags the last (and next-to-last)
// cycle of an n-unit interval. Cleared whenever not running.
module morse_unit_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic [27:0] period_i,
  input  logic [2:0]  units_i,
  output logic        last_o,
  output logic        pre_last_o
);

  logic [27:0] cyc_q, cyc_d;
  logic [2:0]  unit_q, unit_d;
  logic        wrap, done;

  always_comb begin
    wrap   = (cyc_q == period_i - 28'd1);
    done   = wrap && (unit_q == units_i - 3'd1);
    cyc_d  = '0;
    unit_d = '0;
    if (run_i && !wrap) begin
      cyc_d  = cyc_q + 28'd1;
      unit_d = unit_q;
    end else if (run_i && !done) begin
      unit_d = unit_q + 3'd1;
    end
    last_o     = run_i && done;
    // Lets the closing gap hand its final cycle to IDLE for back-to-back transfers.
    pre_last_o = run_i && !done && (cyc_d == period_i - 28'd1) &&
                 (unit_d == units_i - 3'd1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q  <= '0;
      unit_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      unit_q <= unit_d;
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// ASCII to Morse encoder: accepts one character per ready/valid handshake and
// keys morse_o with dot/dash/gap timing in units of dot_period_i cycles.
module morse_encoder
  import morse_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  input  logic [27:0] dot_period_i,
  output logic        ready_o,
  output logic        morse_o,
  output logic        unknown_o,
  output logic        period_error_o
);

  state_e      state_q, state_d;
  logic [27:0] period_q, period_d;
  logic [4:0]  pattern_q, pattern_d;
  logic [2:0]  left_q, left_d;
  logic        unknown_q, unknown_d, perr_q, perr_d;
  logic        transfer, last, pre_last;
  logic [2:0]  units;
  morse_code_t code;

  assign code     = morse_lookup(char_i);
  assign transfer = char_valid_i && (state_q == StIdle);

  always_comb begin
    units = SymGapUnits;
    unique case (state_q)
      StMark:    units = pattern_q[4] ? DashUnits : DotUnits;
      StSymGap:  units = SymGapUnits;
      StCharGap: units = CharGapUnits;
      StWordGap: units = WordGapUnits;
      default:   units = SymGapUnits;
    endcase
  end

  morse_unit_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .run_i      (state_q != StIdle),
    .period_i   (period_q),
    .units_i    (units),
    .last_o     (last),
    .pre_last_o (pre_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (transfer && dot_period_i != '0 && code.valid) begin
          state_d = (code.len == 3'd0) ? StWordGap : StMark;
        end
      end
      StMark:    if (last) state_d = (left_q == 3'd1) ? StCharGap : StSymGap;
      StSymGap:  if (last) state_d = StMark;
      StCharGap: if (pre_last) state_d = StIdle;
      StWordGap: if (pre_last) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    period_d  = period_q;
    pattern_d = pattern_q;
    left_d    = left_q;
    unknown_d = transfer && dot_period_i != '0 && !code.valid;
    perr_d    = transfer && dot_period_i == '0;
    if (transfer) begin
      period_d  = dot_period_i;
      pattern_d = code.pattern;
      left_d    = code.len;
    end else if (state_q == StMark && last) begin
      pattern_d = {pattern_q[3:0], 1'b0};
      left_d    = left_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_q  <= '0;
      pattern_q <= '0;
      left_q    <= '0;
      unknown_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      period_q  <= period_d;
      pattern_q <= pattern_d;
      left_q    <= left_d;
      unknown_q <= unknown_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    ready_o        = (state_q == StIdle);
    morse_o        = (state_q == StMark);
    unknown_o      = unknown_q;
    period_error_o = perr_q;
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder: vector table, corner sequences and
// random characters against a dot/dash string model.
module tb_morse_encoder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  char_i;
  logic        char_valid_i;
  logic [27:0] dot_period_i;
  logic        ready_o, morse_o, unknown_o, period_error_o;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  morse_encoder dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .char_i         (char_i),
    .char_valid_i   (char_valid_i),
    .dot_period_i   (dot_period_i),
    .ready_o        (ready_o),
    .morse_o        (morse_o),
    .unknown_o      (unknown_o),
    .period_error_o (period_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;
    int         p;
    int         hi;
    int         rdy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic string morse_of(input logic [7:0] u);
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  // Expected {ready, morse, unknown, period_error} for each cycle after the transfer.
  task automatic build(input logic [7:0] c, input int p);
    string      s;
    logic [7:0] u;
    exp_q.delete();
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    if (p == 0) begin
      exp_q.push_back(4'b1001);
      return;
    end
    if (u == 8'h20) begin
      repeat (4 * p) exp_q.push_back(4'b0000);
    end else begin
      s = morse_of(u);
      if (s.len() == 0) begin
        exp_q.push_back(4'b1010);
        return;
      end
      for (int i = 0; i < s.len(); i++) begin
        repeat ((s[i] == 8'h2d ? 3 : 1) * p) exp_q.push_back(4'b0100);
        repeat ((i == s.len() - 1 ? 3 : 1) * p) exp_q.push_back(4'b0000);
      end
    end
    exp_q[exp_q.size() - 1] = 4'b1000;
  endtask

  // Called in a cycle where ready_o is high; returns in the cycle ready_o is high again.
  task automatic run_char(input logic [7:0] c, input int p, output int hi, output int rdy_at);
    build(c, p);
    char_i       = c;
    dot_period_i = 28'(p);
    char_valid_i = 1'b1;
    @(posedge clk);
    #1;
    char_valid_i = 1'b0;
    char_i       = 8'($urandom);
    dot_period_i = 28'($urandom);
    hi     = 0;
    rdy_at = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("'%c' P%0d cyc%0d {rdy,mrk,unk,perr}", c, p, k + 1),
            {28'b0, ready_o, morse_o, unknown_o, period_error_o}, {28'b0, exp_q[k]});
      if (morse_o === 1'b1) hi++;
      if (ready_o === 1'b1 && rdy_at == 0) rdy_at = k + 1;
      if (k < exp_q.size() - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check(tag, {28'b0, ready_o, morse_o, unknown_o, period_error_o}, 32'h8);
    end
  endtask

  initial begin
    vec_t vecs[10];
    int hi, rdy, sel, p;
    logic [7:0] c;

    vecs[0] = '{8'h45, 4, 4, 16};   // E
    vecs[1] = '{8'h61, 2, 8, 16};   // a
    vecs[2] = '{8'h41, 2, 8, 16};   // A
    vecs[3] = '{8'h23, 5, 0, 1};    // # unknown
    vecs[4] = '{8'h54, 0, 0, 1};    // T with P=0
    vecs[5] = '{8'h35, 1, 5, 12};   // 5 at minimum period
    vecs[6] = '{8'h5a, 2, 16, 28};  // Z
    vecs[7] = '{8'h20, 3, 0, 12};   // space
    vecs[8] = '{8'h39, 1, 13, 20};  // 9
    vecs[9] = '{8'h71, 3, 30, 48};  // q

    rst_i        = 1'b1;
    char_i       = 8'h45;
    char_valid_i = 1'b1;
    dot_period_i = 28'd2;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {28'b0, ready_o, morse_o, unknown_o, period_error_o}, 32'h8);
    rst_i        = 1'b0;
    char_valid_i = 1'b0;

    foreach (vecs[i]) begin
      run_char(vecs[i].c, vecs[i].p, hi, rdy);
      check($sformatf("vec%0d high cycles", i), hi, vecs[i].hi);
      check($sformatf("vec%0d ready cycle", i), rdy, vecs[i].rdy);
    end
    idle_cycles(2, "after unknown idle");

    // "E E" back-to-back at P=3
    run_char(8'h45, 3, hi, rdy);
    run_char(8'h20, 3, hi, rdy);
    run_char(8'h45, 3, hi, rdy);
    check("EE final ready cycle", rdy, 12);

    // Reset during the second dash of '0' at P=10
    char_i       = 8'h30;
    dot_period_i = 28'd10;
    char_valid_i = 1'b1;
    @(posedge clk);
    #1;
    char_valid_i = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check("second dash mark", morse_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("abort state", {28'b0, ready_o, morse_o, unknown_o, period_error_o}, 32'h8);
    idle_cycles(3, "no resume after abort");
    run_char(8'h54, 10, hi, rdy);
    check("T after reset high cycles", hi, 30);
    check("T after reset ready cycle", rdy, 60);

    // No transfer on an edge with reset asserted
    rst_i        = 1'b1;
    char_i       = 8'h54;
    dot_period_i = 28'd2;
    char_valid_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i        = 1'b0;
    char_valid_i = 1'b0;
    check("no transfer in reset", {28'b0, ready_o, morse_o, unknown_o, period_error_o}, 32'h8);
    idle_cycles(2, "idle after reset transfer");

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      c = 8'h41 + 8'($urandom_range(0, 25));
      else if (sel <= 5) c = 8'h61 + 8'($urandom_range(0, 25));
      else if (sel <= 7) c = 8'h30 + 8'($urandom_range(0, 9));
      else if (sel == 8) c = 8'h20;
      else               c = 8'h21 + 8'($urandom_range(0, 14));
      p = ($urandom_range(0, 12) == 0) ? 0 : $urandom_range(1, 5);
      run_char(c, p, hi, rdy);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2), "random idle");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i, sampled on the rising edge of clk_i.
REQ-002 Port list (name  direction  width  meaning):
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- char_i  in  8  ASCII character to transmit
- char_valid_i  in  1  char_i valid; handshake with ready_o
- dot_period_i  in  28  dot duration in clk_i cycles (P)
- ready_o  out  1  encoder can accept a character
- morse_o  out  1  Morse line, 1 = mark; feeds the receiver's morse_i
- unknown_o  out  1  one-cycle pulse: accepted character not encodable
- period_error_o  out  1  one-cycle pulse: character dropped because P = 0

Function
REQ-003 A transfer SHALL occur on a rising edge where char_valid_i=1 and ready_o=1; char_valid_i SHALL be ignored while ready_o=0.
REQ-004 Encodable set: 'A'-'Z', 'a'-'z' (same codes as uppercase), '0'-'9' (ITU Morse), and space 0x20 (word gap).
REQ-005 dot_period_i and char_i SHALL be latched at the transfer edge; later changes SHALL NOT affect the character in progress.
REQ-006 Timing unit U = P cycles: dot = 1U mark, dash = 3U mark, intra-character gap = 1U space, post-character gap = 3U space, space character = 4U space (7U total after the preceding character's 3U).
REQ-007 FSM states: IDLE, MARK, SYM_GAP, CHAR_GAP, WORD_GAP; ready_o=1 only in IDLE; morse_o=1 only in MARK.
REQ-008 IDLE, transfer of a letter/digit -> MARK, with the first symbol loaded (MSB-first pattern and 3-bit length).
REQ-009 IDLE, transfer of space -> WORD_GAP; transfer of any other code -> stay in IDLE with unknown_o=1 for exactly the next cycle and no change on morse_o.
REQ-010 IDLE, transfer with P=0 -> stay in IDLE with period_error_o=1 for one cycle; this check SHALL take priority over unknown_o.
REQ-011 MARK SHALL last 1U (dot) or 3U (dash), then go to SYM_GAP if symbols remain, otherwise to CHAR_GAP.
REQ-012 SYM_GAP (1U) -> MARK with the next symbol; CHAR_GAP (3U) -> IDLE; WORD_GAP (4U) -> IDLE.
REQ-013 morse_o SHALL be registered: it rises in the first cycle after the transfer edge, and each state lasts exactly n*P cycles.
REQ-014 ready_o SHALL return to 1 exactly (total units)*P cycles after the transfer edge, so back-to-back characters are supported with no extra idle cycle.
REQ-015 Timing SHALL use a 28-bit cycle counter (0..P-1) plus a 3-bit unit counter; there SHALL be no multiplication and no overflow for P up to 2^28-1.

Reset
REQ-016 At a rising edge with rst_i=1, the block SHALL enter IDLE with morse_o=0, ready_o=1, unknown_o=0, period_error_o=0 and all counters cleared.
REQ-017 Reset mid-character SHALL abort the transmission immediately (morse_o=0 from the next cycle); no partial symbol SHALL resume.
REQ-018 Transfers SHALL NOT occur on any edge where rst_i=1.

Structure
REQ-019 A shared package morse_pkg SHALL hold: the FSM state enum; the code record type (3-bit length, 5-bit pattern, valid flag); the lookup function from ASCII to code; and the unit constants (DOT=1, DASH=3, SYM_GAP=1, CHAR_GAP=3, WORD_GAP=4).
REQ-020 A sub-module morse_unit_timer SHALL count P-cycle units and flag the last cycle of an n-unit interval; the FSM and shift logic SHALL stay in morse_encoder.

Verification
REQ-021 P=4, 'E' -> morse_o high for 4 cycles starting the cycle after the transfer, then low for 12 cycles; ready_o=1 16 cycles after the transfer.
REQ-022 P=2, 'a' -> morse_o pattern 2 high, 2 low, 6 high, 6 low; ready_o returns after 16 cycles, identical to 'A'.
REQ-023 P=3, "E E" sent back-to-back -> 3 high, 9 low, 12 low, 3 high, 9 low, with no idle cycle between characters.
REQ-024 '#' (0x23) with P=5 -> unknown_o pulses for 1 cycle, morse_o stays 0, and ready_o stays 1; P=0 with 'T' -> period_error_o pulses for 1 cycle and unknown_o stays 0.
REQ-025 P=10, '0' (five dashes), rst_i asserted during the second dash -> morse_o=0 and ready_o=1 from the next cycle; a new 'T' then gives a clean 30-cycle mark.
REQ-026 P=1, '5' -> exactly 5 single-cycle marks separated by single-cycle spaces, followed by 3 low cycles (minimum-period boundary).
